// File: rtl/spi_cdc_bridge.sv
// spi_cdc_bridge: level/event clock-domain crossing into clk with priming, pending/ack and overrun.
// Optional per-channel saturating event counters when SPI_CDC_EVENT_COUNT_EN is defined.
module spi_cdc_bridge #(
  parameter int unsigned           NUM_LEVEL      = 1,
  parameter int unsigned           NUM_EVENT      = 1,
  parameter int unsigned           SYNC_STAGES    = 2,
  parameter logic [NUM_EVENT-1:0]  EVENT_ANY_EDGE = '0,
  parameter int unsigned           CNT_WIDTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_LEVEL-1:0]          level_in,
  input  logic [NUM_EVENT-1:0]          event_in,
  input  logic [NUM_EVENT-1:0]          event_ack,
  input  logic [NUM_EVENT-1:0]          overrun_clear,
  output logic [NUM_LEVEL-1:0]          level_sync,
  output logic [NUM_EVENT-1:0]          event_pulse,
  output logic [NUM_EVENT-1:0]          event_pending,
  output logic [NUM_EVENT-1:0]          event_overrun,
`ifdef SPI_CDC_EVENT_COUNT_EN
  input  logic [NUM_EVENT-1:0]          count_clear,
  output logic [NUM_EVENT*CNT_WIDTH-1:0] event_count,
`endif
  output logic                          primed
);

  localparam int unsigned PW   = $clog2(SYNC_STAGES + 2);
  localparam int unsigned LAST = SYNC_STAGES - 1;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || CNT_WIDTH == 0) begin : g_bad_param
    $error("spi_cdc_bridge: SYNC_STAGES must be 2..4 and CNT_WIDTH nonzero");
  end

  typedef enum logic {ST_PRIMING = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                              state_q, state_d;
  logic [PW-1:0]                       prime_cnt_q, prime_cnt_d;
  logic [SYNC_STAGES-1:0][NUM_LEVEL-1:0] lvl_q;
  logic [SYNC_STAGES-1:0][NUM_EVENT-1:0] evt_q;
  logic [NUM_EVENT-1:0]                evt_s_q, evt_h_q;
  logic [NUM_EVENT-1:0]                pending_q, pending_d;
  logic [NUM_EVENT-1:0]                overrun_q, overrun_d;
  logic [NUM_EVENT-1:0]                edge_c;

  // Priming FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PRIMING;
      prime_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  // Priming FSM: hold SYNC_STAGES+1 enabled cycles before edges may fire
  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    if (!enable) begin
      state_d     = ST_PRIMING;
      prime_cnt_d = '0;
    end else begin
      case (state_q)
        ST_PRIMING: begin
          if (prime_cnt_q == PW'(SYNC_STAGES)) state_d = ST_RUN;
          else prime_cnt_d = prime_cnt_q + PW'(1);
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_PRIMING;
      endcase
    end
  end

  assign primed = (state_q == ST_RUN);

  // Event stage s sits one flop past the synchronizer; while priming the history
  // follows the synchronizer output so s and h agree when RUN begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q     <= '0;
      evt_q     <= '0;
      evt_s_q   <= '0;
      evt_h_q   <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else if (!enable) begin
      lvl_q     <= '0;
      evt_q     <= '0;
      evt_s_q   <= '0;
      evt_h_q   <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      lvl_q     <= {lvl_q[SYNC_STAGES-2:0], level_in};
      evt_q     <= {evt_q[SYNC_STAGES-2:0], event_in};
      evt_s_q   <= evt_q[LAST];
      evt_h_q   <= (state_q == ST_RUN) ? evt_s_q : evt_q[LAST];
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign edge_c      = ((evt_s_q ^ evt_h_q) & EVENT_ANY_EDGE)
                     | ((evt_s_q & ~evt_h_q) & ~EVENT_ANY_EDGE);
  assign event_pulse = (state_q == ST_RUN) ? edge_c : '0;

  // A new pulse always leaves pending set; overrun set beats clear
  always_comb begin
    pending_d = event_pulse | (pending_q & ~event_ack);
    overrun_d = (overrun_q & ~overrun_clear) | (event_pulse & pending_q & ~event_ack);
  end

  assign level_sync    = lvl_q[LAST];
  assign event_pending = pending_q;
  assign event_overrun = overrun_q;

`ifdef SPI_CDC_EVENT_COUNT_EN
  logic [NUM_EVENT-1:0][CNT_WIDTH-1:0] count_q;

  // Saturating per-channel event counters; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (!enable) begin
      count_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_EVENT); i++) begin
        if (count_clear[i]) count_q[i] <= '0;
        else if (event_pulse[i] && (count_q[i] != '1)) count_q[i] <= count_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  assign event_count = count_q;
`endif

endmodule

// File: tb/tb_spi_cdc_bridge.sv
// Directed self-checking bench for spi_cdc_bridge (2 event channels, ch1 any-edge, SYNC_STAGES=2).
module tb_spi_cdc_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [0:0] level_in;
  logic [1:0] event_in;
  logic [1:0] event_ack;
  logic [1:0] overrun_clear;
  logic [0:0] level_sync;
  logic [1:0] event_pulse;
  logic [1:0] event_pending;
  logic [1:0] event_overrun;
  logic       primed;
`ifdef SPI_CDC_EVENT_COUNT_EN
  logic [1:0] count_clear;
  logic [3:0] event_count;
`endif

  int checks = 0;
  int errors = 0;
  int n0, n1;

  always #5 clk = ~clk;

  spi_cdc_bridge #(
    .NUM_LEVEL(1), .NUM_EVENT(2), .SYNC_STAGES(2),
    .EVENT_ANY_EDGE(2'b10), .CNT_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .level_in(level_in), .event_in(event_in),
    .event_ack(event_ack), .overrun_clear(overrun_clear),
    .level_sync(level_sync), .event_pulse(event_pulse),
    .event_pending(event_pending), .event_overrun(event_overrun),
`ifdef SPI_CDC_EVENT_COUNT_EN
    .count_clear(count_clear), .event_count(event_count),
`endif
    .primed(primed)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle high on the selected event inputs, consuming edge 0
  task automatic blip(input logic [1:0] m);
    event_in = m;
    tick();
    event_in = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; level_in = 1'b0; event_in = 2'b00;
    event_ack = 2'b00; overrun_clear = 2'b00;
`ifdef SPI_CDC_EVENT_COUNT_EN
    count_clear = 2'b00;
`endif
    tick(); tick();
    chk("rst_level", 32'(level_sync), 32'h0);
    chk("rst_pulse", 32'(event_pulse), 32'h0);
    chk("rst_pending", 32'(event_pending), 32'h0);
    chk("rst_overrun", 32'(event_overrun), 32'h0);
    chk("rst_primed", 32'(primed), 32'h0);
    rst = 1'b0;
    tick();

    // Priming with inputs high from the moment enable rises
    enable = 1'b1; event_in = 2'b11; level_in = 1'b1;
    tick();
    chk("prime_e1_primed", 32'(primed), 32'h0);
    chk("prime_e1_pulse", 32'(event_pulse), 32'h0);
    tick();
    chk("prime_e2_primed", 32'(primed), 32'h0);
    chk("prime_e2_pulse", 32'(event_pulse), 32'h0);
    chk("prime_e2_level", 32'(level_sync), 32'h1);
    tick();
    chk("prime_e3_primed", 32'(primed), 32'h1);
    chk("prime_e3_pulse", 32'(event_pulse), 32'h0);
    tick();
    chk("prime_e4_pulse", 32'(event_pulse), 32'h0);
    tick();
    chk("prime_pending", 32'(event_pending), 32'h0);

    // Falling inputs: only the any-edge channel registers an event
    event_in = 2'b00; level_in = 1'b0;
    repeat (5) tick();
    chk("fall_pending", 32'(event_pending), 32'h2);
    event_ack = 2'b11;
    tick();
    event_ack = 2'b00;
    chk("fall_ack_pending", 32'(event_pending), 32'h0);
    chk("fall_ack_overrun", 32'(event_overrun), 32'h0);

    // Latency: change before edge 0
    event_in = 2'b01; level_in = 1'b1;
    tick();
    chk("lat_e0_level", 32'(level_sync), 32'h0);
    chk("lat_e0_pulse", 32'(event_pulse), 32'h0);
    tick();
    chk("lat_e1_level", 32'(level_sync), 32'h1);
    chk("lat_e1_pulse", 32'(event_pulse), 32'h0);
    tick();
    chk("lat_e2_pulse", 32'(event_pulse), 32'h1);
    chk("lat_e2_pending", 32'(event_pending), 32'h0);
    tick();
    chk("lat_e3_pulse", 32'(event_pulse), 32'h0);
    chk("lat_e3_pending", 32'(event_pending), 32'h1);
    event_ack = 2'b01;
    tick();
    event_ack = 2'b00;
    chk("lat_ack_pending", 32'(event_pending), 32'h0);

    // Any-edge vs rising: 0->1->0 with 10-cycle spacing, acks held
    event_in = 2'b00;
    repeat (6) tick();
    n0 = 0; n1 = 0;
    event_ack = 2'b11;
    for (int c = 0; c < 30; c++) begin
      if (c == 0) event_in = 2'b11;
      if (c == 10) event_in = 2'b00;
      tick();
      n0 += int'(event_pulse[0]);
      n1 += int'(event_pulse[1]);
    end
    event_ack = 2'b00;
    chk("any_ch1_pulses", 32'(n1), 32'd2);
    chk("any_ch0_pulses", 32'(n0), 32'd1);
    chk("any_pending", 32'(event_pending), 32'h0);
    chk("any_overrun", 32'(event_overrun), 32'h0);

    // Overrun: two ch0 events 6 cycles apart, no ack
    blip(2'b01);
    tick(); tick();
    chk("ovr_p1_pulse", 32'(event_pulse), 32'h1);
    tick(); tick(); tick();
    chk("ovr_p1_pending", 32'(event_pending), 32'h1);
    chk("ovr_p1_overrun", 32'(event_overrun), 32'h0);
    blip(2'b01);
    tick(); tick();
    chk("ovr_p2_pulse", 32'(event_pulse), 32'h1);
    tick();
    chk("ovr_set", 32'(event_overrun), 32'h1);
    tick(); tick(); tick();
    chk("ovr_sticky", 32'(event_overrun), 32'h1);
    overrun_clear = 2'b01;
    tick();
    overrun_clear = 2'b00;
    chk("ovr_cleared", 32'(event_overrun), 32'h0);
    chk("ovr_clr_pending", 32'(event_pending), 32'h1);

    // Ack in the same cycle as a new pulse
    blip(2'b01);
    tick(); tick();
    chk("ackp_pulse", 32'(event_pulse), 32'h1);
    event_ack = 2'b01;
    tick();
    event_ack = 2'b00;
    chk("ackp_pending", 32'(event_pending), 32'h1);
    chk("ackp_overrun", 32'(event_overrun), 32'h0);

    // Enable drop with pending and overrun set
    blip(2'b01);
    tick(); tick(); tick();
    chk("drop_pre_overrun", 32'(event_overrun), 32'h1);
    chk("drop_pre_pending", 32'(event_pending), 32'h1);
    enable = 1'b0;
    tick();
    chk("drop_level", 32'(level_sync), 32'h0);
    chk("drop_pulse", 32'(event_pulse), 32'h0);
    chk("drop_pending", 32'(event_pending), 32'h0);
    chk("drop_overrun", 32'(event_overrun), 32'h0);
    chk("drop_primed", 32'(primed), 32'h0);
    enable = 1'b1;
    tick();
    chk("reprime_e1", 32'(primed), 32'h0);
    tick();
    chk("reprime_e2", 32'(primed), 32'h0);
    tick();
    chk("reprime_e3", 32'(primed), 32'h1);

`ifdef SPI_CDC_EVENT_COUNT_EN
    // Saturating counter on ch0, acks held so no overruns
    event_ack = 2'b01;
    tick();
    chk("cnt_start", 32'(event_count), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      blip(2'b01);
      tick(); tick(); tick();
      chk($sformatf("cnt_ev%0d", k), 32'(event_count[1:0]), (k < 3) ? 32'(k) : 32'd3);
    end
    chk("cnt_ch1", 32'(event_count[3:2]), 32'h0);
    count_clear = 2'b01;
    tick();
    count_clear = 2'b00;
    chk("cnt_clear", 32'(event_count[1:0]), 32'h0);
    blip(2'b01);
    tick(); tick();
    chk("cnt_clr_pulse", 32'(event_pulse), 32'h1);
    count_clear = 2'b01;
    tick();
    count_clear = 2'b00;
    chk("cnt_clr_wins", 32'(event_count[1:0]), 32'h0);
    event_ack = 2'b00;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
